fpu_mul_half: RTL and testbench
===============================

FPU_MUL_HALF -- requirements
Module: fpu_mul_half

Interface
REQ-001 SHALL have one clock and an asynchronous active-high reset.
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-high reset.
REQ-002 SHALL have the following ports, in this order:
- in_valid  in  1  operand/rounding-mode beat valid.
- in_ready  out  1  block accepts the beat this cycle.
- rs1  in  16  half-precision operand A.
- rs2  in  16  half-precision operand B.
- rm  in  3  instruction rounding mode; fpu_rm_t encoding.
- frm  in  3  dynamic rounding mode; used when rm = RM_DYN.
- out_valid  out  1  result beat valid.
- out_ready  in  1  consumer accepts the result.
- result  out  16  half-precision product.
- fflags  out  5  bits are {NV, DZ, OF, UF, NX}.

Function
REQ-003 SHALL be a 2-stage pipeline.
- S1: unpack, 11x11 significand multiply, exponent sum minus bias 15.
- S2: normalize, round, pack, flags.
REQ-004 SHALL accept a beat when in_valid && in_ready.
REQ-005 SHALL transfer a result when out_valid && out_ready.
REQ-006 SHALL drive in_ready = !s1_valid || S1 advances this cycle. S1 advances when !s2_valid || out_ready.
REQ-007 SHALL present the result 2 cycles after acceptance when out_ready is held high.
REQ-008 SHALL sustain a throughput of 1 beat per cycle.
REQ-009 SHALL hold result and fflags stable while out_valid && !out_ready.
REQ-010 SHALL never drop, duplicate, or reorder beats.
REQ-011 SHALL resolve the rounding mode as follows.
- rm = RM_DYN: effective mode = frm.
- Legal effective modes: RNE, RTZ, RDN, RUP, RMM.
- Any other effective value: result = HALF_NAN, fflags = NV.
REQ-012 SHALL set result sign = sign(rs1) XOR sign(rs2) for all non-NaN results.
REQ-013 SHALL treat subnormal inputs as signed zero. No flag is raised for this.
REQ-014 SHALL handle special operands as follows.
- Either operand NaN: result HALF_NAN. NV is set only if that NaN is signaling (mantissa bit 9 = 0).
- inf x 0: result HALF_NAN, NV set.
- inf x nonzero: result signed inf.
- 0 x finite: result signed zero.
REQ-015 SHALL normalize the product.
- If product bit 21 is set: shift right by 1 and increment the exponent.
- Guard = next bit below the kept 11 bits.
- Sticky = OR of all remaining lower bits.
REQ-016 SHALL round per the effective mode.
- RNE and RMM: nearest; ties to even (RNE) or away from zero (RMM).
- RTZ: truncate.
- RDN and RUP: directed toward -inf and +inf, sign-aware.
- Mantissa carry-out increments the exponent.
REQ-017 SHALL set NX whenever guard or sticky is nonzero.
REQ-018 SHALL handle overflow when the post-round exponent is >= 31.
- Sets OF and NX.
- Result = signed inf for RNE, RMM, and RUP with + sign, and RDN with - sign.
- Result = signed HALF_MAX (16'h7BFF magnitude) otherwise.
REQ-019 SHALL handle underflow when the post-round exponent is <= 0 for a nonzero finite product.
- Result = signed zero.
- Sets UF and NX.
REQ-020 SHALL drive DZ = 0 always.

Reset
REQ-021 SHALL set s1_valid, s2_valid and out_valid to 0 while RST is high.
REQ-022 SHALL drive in_ready = 1 once RST is low and the pipeline is empty.
REQ-023 SHALL reset result and fflags to 16'h0000 and 5'b0.
REQ-024 SHALL discard in-flight beats on reset mid-operation. No result is emitted for them.
REQ-025 SHALL not reset datapath registers other than result and fflags.

Structure
REQ-026 SHALL place the following in fpu_types_pkg:
- HALF_BIAS = 15.
- HALF_MAX = 16'h7BFF.
- typedef fflags_t: packed {NV, DZ, OF, UF, NX}.
- The existing HALF_NAN, HALF_INF and fpu_rm_t.
REQ-027 SHALL implement rounding in a combinational sub-module fpu_round_half.
- Inputs: sign, exponent, 11-bit significand, guard, sticky, mode.
- Outputs: packed 16-bit value and {OF, UF, NX}.
- Instantiated once in S2.
REQ-028 SHALL be 120-400 lines of RTL.

Verification
REQ-029 SHALL cover these directed scenarios:
- 3C00 x 3C00, rm=RNE, out_ready=1 -> 3C00, fflags 0, out_valid exactly 2 cycles after acceptance.
- 4000 x 4200 (2 x 3), RNE -> 4600, fflags 0.
- 3C01 x 3C01 -> 3C02 for RNE and RTZ, 3C03 for RUP; NX set in all three modes.
- 7BFF x 7BFF -> 7C00 for RNE, 7BFF for RTZ; fflags OF|NX in both.
- 7C00 x 0000 -> FFFF, NV. Also rm=RM_DYN with frm=3'b101 -> FFFF, NV.
- Backpressure and reset.
  - Setup: 4 back-to-back beats, out_ready low for 3 cycles.
  - Required: in_ready drops once S1 and S2 are full; all 4 results emerge in order with none lost.
  - Required: RST asserted mid-stream clears out_valid immediately.

Source files
------------

// File: rtl/fpu_types_pkg.sv
// Shared half-precision constants, rounding-mode encoding and the IEEE exception flag layout.
package fpu_types_pkg;

    localparam int          HALF_BIAS = 15;
    localparam logic [15:0] HALF_NAN  = 16'hFFFF;
    localparam logic [15:0] HALF_INF  = 16'h7C00;
    localparam logic [15:0] HALF_MAX  = 16'h7BFF;

    typedef enum logic [2:0] {
        RNE    = 3'b000,
        RTZ    = 3'b001,
        RDN    = 3'b010,
        RUP    = 3'b011,
        RMM    = 3'b100,
        RM_DYN = 3'b111
    } fpu_rm_t;

    typedef struct packed {
        logic nv;
        logic dz;
        logic of;
        logic uf;
        logic nx;
    } fflags_t;

endpackage

// File: rtl/fpu_round_half.sv
// Rounds a normalized 11-bit significand to half precision and packs it, flagging
// overflow, underflow (flush to signed zero) and inexact results.
module fpu_round_half
    import fpu_types_pkg::*;
(
    input  logic              sign,
    input  logic signed [7:0] exp_in,
    input  logic [10:0]       sig,
    input  logic              guard,
    input  logic              sticky,
    input  fpu_rm_t           mode,
    output logic [15:0]       value,
    output logic              of_flag,
    output logic              uf_flag,
    output logic              nx_flag
);

    logic              inexact;
    logic              inc;
    logic              to_inf;
    logic [11:0]       sig_r;
    logic signed [7:0] exp_r;
    logic [9:0]        man;

    always_comb begin
        inexact = guard | sticky;
        case (mode)
            RNE:     inc = guard & (sticky | sig[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign & inexact;
            RUP:     inc = !sign & inexact;
            RMM:     inc = guard;
            default: inc = 1'b0;
        endcase

        // A carry out of the significand leaves 1.000..0 at the next exponent.
        sig_r = {1'b0, sig} + {11'b0, inc};
        exp_r = sig_r[11] ? exp_in + 8'sd1 : exp_in;
        man   = sig_r[11] ? sig_r[10:1] : sig_r[9:0];

        to_inf = (mode == RNE) || (mode == RMM) ||
                 (mode == RUP && !sign) || (mode == RDN && sign);

        of_flag = 1'b0;
        uf_flag = 1'b0;
        nx_flag = inexact;
        value   = {sign, exp_r[4:0], man};
        if (exp_r >= 8'sd31) begin
            of_flag = 1'b1;
            nx_flag = 1'b1;
            value   = to_inf ? {sign, HALF_INF[14:0]} : {sign, HALF_MAX[14:0]};
        end else if (exp_r <= 8'sd0) begin
            uf_flag = 1'b1;
            nx_flag = 1'b1;
            value   = {sign, 15'b0};
        end
    end

endmodule

// File: rtl/fpu_mul_half.sv
// Two-stage half-precision multiplier: S1 unpacks, classifies and multiplies significands;
// S2 normalizes, rounds and registers the result with its exception flags.
module fpu_mul_half
    import fpu_types_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] rs1,
    input  logic [15:0] rs2,
    input  logic [2:0]  rm,
    input  logic [2:0]  frm,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] result,
    output logic [4:0]  fflags
);

    // Handshake: a beat moves on any edge where valid && ready; S2 takes S1 whenever S2 is
    // empty or its result is being consumed, and S1 refills whenever it is empty or draining.
    logic s1_valid, s2_valid, s1_adv;
    assign s1_adv    = !s2_valid || out_ready;
    assign in_ready  = !s1_valid || s1_adv;
    assign out_valid = s2_valid;

    logic [4:0]        ea, eb;
    logic [9:0]        ma, mb;
    logic              a_nan, b_nan, a_snan, b_snan, a_inf, b_inf, a_zero, b_zero;
    logic [2:0]        eff_rm;
    logic              d_special, d_spec_nv, d_sign;
    logic [15:0]       d_spec_res;
    logic signed [7:0] d_exp;
    logic [21:0]       d_prod;

    always_comb begin
        ea     = rs1[14:10];
        eb     = rs2[14:10];
        ma     = rs1[9:0];
        mb     = rs2[9:0];
        a_nan  = (&ea) && (|ma);
        b_nan  = (&eb) && (|mb);
        a_snan = a_nan && !ma[9];
        b_snan = b_nan && !mb[9];
        a_inf  = (&ea) && !(|ma);
        b_inf  = (&eb) && !(|mb);
        // Subnormals are flushed: a zero exponent field means zero.
        a_zero = (ea == 5'd0);
        b_zero = (eb == 5'd0);
        eff_rm = (rm == RM_DYN) ? frm : rm;
        d_sign = rs1[15] ^ rs2[15];
        d_prod = {11'b0, 1'b1, ma} * {11'b0, 1'b1, mb};
        d_exp  = {3'b0, ea} + {3'b0, eb} - 8'(HALF_BIAS);

        d_special  = 1'b1;
        d_spec_nv  = 1'b0;
        d_spec_res = HALF_NAN;
        if (eff_rm > RMM)
            d_spec_nv = 1'b1;
        else if (a_nan || b_nan)
            d_spec_nv = a_snan || b_snan;
        else if ((a_inf && b_zero) || (a_zero && b_inf))
            d_spec_nv = 1'b1;
        else if (a_inf || b_inf)
            d_spec_res = {d_sign, HALF_INF[14:0]};
        else if (a_zero || b_zero)
            d_spec_res = {d_sign, 15'b0};
        else
            d_special = 1'b0;
    end

    logic              s1_special, s1_spec_nv, s1_sign;
    logic [15:0]       s1_spec_res;
    logic signed [7:0] s1_exp;
    logic [21:0]       s1_prod;
    logic [2:0]        s1_mode;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            s1_valid <= 1'b0;
        else if (in_ready)
            s1_valid <= in_valid;
    end

    always_ff @(posedge clk) begin
        if (in_valid && in_ready) begin
            s1_special  <= d_special;
            s1_spec_nv  <= d_spec_nv;
            s1_spec_res <= d_spec_res;
            s1_sign     <= d_sign;
            s1_exp      <= d_exp;
            s1_prod     <= d_prod;
            s1_mode     <= eff_rm;
        end
    end

    logic [10:0]       n_sig;
    logic              n_guard, n_sticky;
    logic signed [7:0] n_exp;
    logic [15:0]       r_value;
    logic              r_of, r_uf, r_nx;

    always_comb begin
        if (s1_prod[21]) begin
            n_sig    = s1_prod[21:11];
            n_guard  = s1_prod[10];
            n_sticky = |s1_prod[9:0];
            n_exp    = s1_exp + 8'sd1;
        end else begin
            n_sig    = s1_prod[20:10];
            n_guard  = s1_prod[9];
            n_sticky = |s1_prod[8:0];
            n_exp    = s1_exp;
        end
    end

    fpu_round_half u_round (
        .sign    (s1_sign),
        .exp_in  (n_exp),
        .sig     (n_sig),
        .guard   (n_guard),
        .sticky  (n_sticky),
        .mode    (fpu_rm_t'(s1_mode)),
        .value   (r_value),
        .of_flag (r_of),
        .uf_flag (r_uf),
        .nx_flag (r_nx)
    );

    fflags_t d2_flags, flags_q;
    logic [15:0] d2_result;

    always_comb begin
        d2_flags = '0;
        if (s1_special) begin
            d2_result   = s1_spec_res;
            d2_flags.nv = s1_spec_nv;
        end else begin
            d2_result   = r_value;
            d2_flags.of = r_of;
            d2_flags.uf = r_uf;
            d2_flags.nx = r_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2_valid <= 1'b0;
            result   <= 16'h0000;
            flags_q  <= '0;
        end else if (s1_adv) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                result  <= d2_result;
                flags_q <= d2_flags;
            end
        end
    end

    assign fflags = flags_q;

endmodule

// File: tb/tb_fpu_mul_half.sv
// Bench for fpu_mul_half: directed vector table, random traffic against a real-arithmetic
// reference model, and hand-written backpressure and mid-stream reset sequences.
module tb_fpu_mul_half;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [15:0] rs1 = '0, rs2 = '0;
    logic [2:0]  rm = '0, frm = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [15:0] result;
    logic [4:0]  fflags;

    always #5 clk = ~clk;

    fpu_mul_half dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs1       (rs1),
        .rs2       (rs2),
        .rm        (rm),
        .frm       (frm),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .fflags    (fflags)
    );

    int checks = 0;
    int errors = 0;
    logic [20:0] exp_q[$];
    bit mon_en = 1'b0;
    int popped = 0;
    bit prev_stall = 1'b0;
    logic [20:0] prev_out = '0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // ---------------- reference model ----------------
    function automatic real pow2(input int e);
        real p = 1.0;
        if (e >= 0) for (int i = 0; i < e; i++) p = p * 2.0;
        else        for (int i = 0; i < -e; i++) p = p / 2.0;
        return p;
    endfunction

    function automatic logic [20:0] ref_mul(input logic [15:0] a, input logic [15:0] b,
                                            input logic [2:0] rmi, input logic [2:0] frmi);
        logic [2:0] eff;
        bit a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sgn, inexact, up, to_inf;
        real v, scaled, frac;
        int e, ip, big_e;
        eff    = (rmi == 3'd7) ? frmi : rmi;
        a_nan  = (a[14:10] == 5'd31) && (a[9:0] != 0);
        b_nan  = (b[14:10] == 5'd31) && (b[9:0] != 0);
        a_inf  = (a[14:10] == 5'd31) && (a[9:0] == 0);
        b_inf  = (b[14:10] == 5'd31) && (b[9:0] == 0);
        a_zero = (a[14:10] == 5'd0);
        b_zero = (b[14:10] == 5'd0);
        sgn    = a[15] ^ b[15];
        if (eff > 3'd4) return {16'hFFFF, 5'b10000};
        if (a_nan || b_nan)
            return {16'hFFFF, ((a_nan && !a[9]) || (b_nan && !b[9])) ? 5'b10000 : 5'b00000};
        if ((a_inf && b_zero) || (a_zero && b_inf)) return {16'hFFFF, 5'b10000};
        if (a_inf || b_inf) return {sgn, 15'h7C00, 5'b0};
        if (a_zero || b_zero) return {sgn, 15'h0000, 5'b0};
        v = real'(1024 + int'(a[9:0])) * pow2(int'(a[14:10]) - 25) *
            real'(1024 + int'(b[9:0])) * pow2(int'(b[14:10]) - 25);
        e = -40;
        while (pow2(e + 1) <= v) e++;
        scaled  = v / pow2(e - 10);
        ip      = int'($floor(scaled));
        frac    = scaled - real'(ip);
        inexact = (frac != 0.0);
        case (eff)
            3'd0:    up = (frac > 0.5) || (frac == 0.5 && (ip % 2 == 1));
            3'd1:    up = 1'b0;
            3'd2:    up = sgn && inexact;
            3'd3:    up = !sgn && inexact;
            default: up = (frac >= 0.5);
        endcase
        if (up) ip++;
        if (ip == 2048) begin ip = 1024; e++; end
        big_e = e + 15;
        if (big_e >= 31) begin
            to_inf = (eff == 3'd0) || (eff == 3'd4) || (eff == 3'd3 && !sgn) || (eff == 3'd2 && sgn);
            return {sgn, to_inf ? 15'h7C00 : 15'h7BFF, 5'b00101};
        end
        if (big_e <= 0) return {sgn, 15'h0000, 5'b00011};
        return {sgn, 5'(big_e), 10'(ip - 1024), 4'b0000, inexact};
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else if (mon_en) begin
            if (prev_stall) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'({result, fflags}), 32'(prev_out));
            end
            if (in_valid && in_ready) exp_q.push_back(ref_mul(rs1, rs2, rm, frm));
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_out actual=%h required=none", result);
                end else begin
                    logic [20:0] e;
                    e = exp_q.pop_front();
                    check("sb_result", 32'(result), 32'(e[20:5]));
                    check("sb_fflags", 32'(fflags), 32'(e[4:0]));
                    popped++;
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_out   = {result, fflags};
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [2:0] rmi, input logic [2:0] frmi);
        int n = 0;
        @(posedge clk);
        #1;
        rs1 = a; rs2 = b; rm = rmi; frm = frmi; in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (!in_ready) begin
            fail("accept_timeout");
            in_valid = 1'b0;
        end
    endtask

    task automatic drain(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            n++;
            @(negedge clk);
        end
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    function automatic logic [15:0] rand_half();
        logic [15:0] specials[8] = '{16'h0000, 16'h8000, 16'h7C00, 16'hFC00,
                                     16'h7E00, 16'h7C01, 16'h0001, 16'h3C00};
        if ($urandom_range(0, 9) == 0) return specials[$urandom_range(0, 7)];
        return {1'($urandom_range(0, 1)), 5'($urandom_range(1, 30)), 10'($urandom_range(0, 1023))};
    endfunction

    typedef struct {
        logic [15:0] a, b;
        logic [2:0]  rm, frm;
        logic [15:0] res;
        logic [4:0]  fl;
    } vec_t;
    vec_t vecs[$];

    task automatic add_vec(input logic [15:0] a, input logic [15:0] b, input logic [2:0] rmi,
                           input logic [2:0] frmi, input logic [15:0] res, input logic [4:0] fl);
        vec_t v;
        v.a = a; v.b = b; v.rm = rmi; v.frm = frmi; v.res = res; v.fl = fl;
        vecs.push_back(v);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        int lat;
        @(posedge clk);
        #1;
        rs1 = v.a; rs2 = v.b; rm = v.rm; frm = v.frm; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check($sformatf("vec%0d_in_ready", idx), 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!out_valid && lat < 8) begin
            lat++;
            @(negedge clk);
        end
        check($sformatf("vec%0d_latency", idx), 32'(lat), 32'd2);
        check($sformatf("vec%0d_result", idx), 32'(result), 32'(v.res));
        check($sformatf("vec%0d_fflags", idx), 32'(fflags), 32'(v.fl));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        bit rand_done = 1'b0;
        bit saw_stall = 1'b0;
        int base, n, ghosts;

        // ---------------- reset state ----------------
        repeat (3) @(negedge clk);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_result", 32'(result), 32'd0);
        check("rst_fflags", 32'(fflags), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_in_ready", 32'(in_ready), 32'd1);
        check("idle_out_valid", 32'(out_valid), 32'd0);

        // ---------------- directed table ----------------
        add_vec(16'h3C00, 16'h3C00, 3'd0, 3'd0, 16'h3C00, 5'b00000);
        add_vec(16'h4000, 16'h4200, 3'd0, 3'd0, 16'h4600, 5'b00000);
        add_vec(16'h3C01, 16'h3C01, 3'd0, 3'd0, 16'h3C02, 5'b00001);
        add_vec(16'h3C01, 16'h3C01, 3'd1, 3'd0, 16'h3C02, 5'b00001);
        add_vec(16'h3C01, 16'h3C01, 3'd3, 3'd0, 16'h3C03, 5'b00001);
        add_vec(16'h3C01, 16'h3C01, 3'd7, 3'd1, 16'h3C02, 5'b00001);
        add_vec(16'h7BFF, 16'h7BFF, 3'd0, 3'd0, 16'h7C00, 5'b00101);
        add_vec(16'h7BFF, 16'h7BFF, 3'd1, 3'd0, 16'h7BFF, 5'b00101);
        add_vec(16'hFBFF, 16'h7BFF, 3'd2, 3'd0, 16'hFC00, 5'b00101);
        add_vec(16'hFBFF, 16'h7BFF, 3'd3, 3'd0, 16'hFBFF, 5'b00101);
        add_vec(16'h7C00, 16'h0000, 3'd0, 3'd0, 16'hFFFF, 5'b10000);
        add_vec(16'h7C00, 16'h0000, 3'd7, 3'd5, 16'hFFFF, 5'b10000);
        add_vec(16'h4000, 16'h4000, 3'd7, 3'd5, 16'hFFFF, 5'b10000);
        add_vec(16'h4000, 16'h4000, 3'd6, 3'd0, 16'hFFFF, 5'b10000);
        add_vec(16'hBC00, 16'h3C00, 3'd0, 3'd0, 16'hBC00, 5'b00000);
        add_vec(16'h0400, 16'h0400, 3'd0, 3'd0, 16'h0000, 5'b00011);
        add_vec(16'h0001, 16'h3C00, 3'd0, 3'd0, 16'h0000, 5'b00000);
        add_vec(16'h8001, 16'h3C00, 3'd0, 3'd0, 16'h8000, 5'b00000);
        add_vec(16'h7E00, 16'h3C00, 3'd0, 3'd0, 16'hFFFF, 5'b00000);
        add_vec(16'h7C01, 16'h3C00, 3'd0, 3'd0, 16'hFFFF, 5'b10000);
        add_vec(16'hFC00, 16'h4000, 3'd0, 3'd0, 16'hFC00, 5'b00000);
        add_vec(16'h3C03, 16'h3E00, 3'd0, 3'd0, 16'h3E04, 5'b00001);
        add_vec(16'h3C03, 16'h3E00, 3'd4, 3'd0, 16'h3E05, 5'b00001);
        add_vec(16'h3C01, 16'h3E00, 3'd0, 3'd0, 16'h3E02, 5'b00001);
        foreach (vecs[i]) run_vec(i, vecs[i]);

        // ---------------- random traffic with random backpressure ----------------
        @(posedge clk);
        #1;
        mon_en = 1'b1;
        fork
            begin
                for (int i = 0; i < 400; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk);
                        #1;
                        in_valid = 1'b0;
                    end
                    send(rand_half(), rand_half(), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
                end
                @(posedge clk);
                #1;
                in_valid = 1'b0;
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        drain("random_drain");

        // ---------------- backpressure: 4 beats, out_ready low 3 cycles ----------------
        base = popped;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        fork
            begin
                send(16'h3C00, 16'h4000, 3'd0, 3'd0);
                send(16'h4000, 16'h4200, 3'd0, 3'd0);
                send(16'h3C01, 16'h3C01, 3'd3, 3'd0);
                send(16'hC400, 16'h3E00, 3'd0, 3'd0);
                @(posedge clk);
                #1;
                in_valid = 1'b0;
            end
            begin
                @(posedge clk);
                #1;
                repeat (3) begin
                    @(negedge clk);
                    if (!in_ready) saw_stall = 1'b1;
                end
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain("bp_drain");
        check("bp_in_ready_drop", 32'(saw_stall), 32'd1);
        check("bp_count", 32'(popped - base), 32'd4);

        // ---------------- reset mid-stream ----------------
        out_ready = 1'b0;
        send(16'h4000, 16'h4000, 3'd0, 3'd0);
        send(16'h4200, 16'h4200, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 20) begin
            n++;
            @(negedge clk);
        end
        if (!out_valid) fail("mid_out_valid_wait");
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_result", 32'(result), 32'd0);
        check("mid_rst_fflags", 32'(fflags), 32'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", 32'(in_ready), 32'd1);
        ghosts = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ghosts++;
        end
        check("post_rst_no_ghost", 32'(ghosts), 32'd0);
        base = popped;
        send(16'h3C00, 16'h4000, 3'd0, 3'd0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        drain("post_rst_drain");
        check("post_rst_count", 32'(popped - base), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
